ir_nec_decoder: RTL

Parametrised NEC infrared frame decoder, the next-generation replacement for the fixed 8-bit IR receiver in the remote-control designs. It samples the demodulated receiver pin and decodes full 32-bit NEC frames: 8-bit address, inverted address, 8-bit command, inverted command. It checks frame integrity, optionally filters by address, and detects repeat codes. Decoded address and command go to downstream consumers (beeper, 7-segment display, LED control) with single-cycle valid, repeat and error strobes.

---
 rtl/ir_nec_decoder_pkg.sv | 33 +++
 rtl/ir_input_filter.sv | 52 +++++
 rtl/ir_nec_decoder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ir_nec_decoder_pkg.sv
// Shared NEC definitions: FSM state encodings, protocol time windows in microseconds,
// and a helper that converts a window edge to clock cycles.
package ir_nec_decoder_pkg;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLeadL = 3'd1;
    localparam logic [2:0] StLeadH = 3'd2;
    localparam logic [2:0] StBitL  = 3'd3;
    localparam logic [2:0] StBitH  = 3'd4;
    localparam logic [2:0] StStop  = 3'd5;

    localparam int unsigned LeadMinUs  = 8000;
    localparam int unsigned LeadMaxUs  = 10000;
    localparam int unsigned DataMinUs  = 4000;
    localparam int unsigned DataMaxUs  = 5000;
    localparam int unsigned RptMinUs   = 2000;
    localparam int unsigned RptMaxUs   = 2500;
    localparam int unsigned MarkMinUs  = 400;
    localparam int unsigned MarkMaxUs  = 720;
    localparam int unsigned ZeroMinUs  = 400;
    localparam int unsigned ZeroMaxUs  = 720;
    localparam int unsigned OneMinUs   = 1400;
    localparam int unsigned OneMaxUs   = 1900;
    localparam int unsigned StopMinUs  = 400;
    localparam int unsigned StopMaxUs  = 720;
    localparam int unsigned PhaseMaxUs = 12000;

    // 64-bit product so slow clocks keep sub-microsecond precision and fast ones cannot overflow.
    function automatic int unsigned us_to_cyc(input int unsigned us, input int unsigned clk_hz);
        return 32'((64'(us) * 64'(clk_hz)) / 64'd1_000_000);
    endfunction

endpackage

// File: rtl/ir_input_filter.sv
// Two-flop synchroniser followed by a stable-level filter; emits the filtered level and
// single-cycle rise/fall strobes aligned with the level change.
module ir_input_filter #(
    parameter int unsigned FILT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = $clog2(FILT_CYC + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          rise_q;
    logic          fall_q;
    logic          flip;

    // The new value must be seen for FILT_CYC consecutive cycles before the level follows.
    assign flip = (sync_q[1] != level_q) && (cnt_q == CW'(FILT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            rise_q <= flip & sync_q[1];
            fall_q <= flip & ~sync_q[1];
            if (sync_q[1] == level_q || flip) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (flip) begin
                level_q <= sync_q[1];
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC IR frame decoder: measures filtered mark/space durations, assembles 32-bit frames
// LSB first, validates them and flags repeat codes with single-cycle strobes.
module ir_nec_decoder
    import ir_nec_decoder_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned FILT_CYC   = 64,
    parameter bit          ADDR_CHECK = 1'b0,
    parameter logic [7:0]  ADDR       = 8'h00,
    parameter bit          REPEAT_EN  = 1'b1
) (
    input  logic       CLK_50M,
    input  logic       RST_N,
    input  logic       IR_DATA,
    output logic [7:0] o_ir_addr,
    output logic [7:0] o_ir_data,
    output logic       o_valid,
    output logic       o_repeat,
    output logic       o_err,
    output logic       o_busy
);

    localparam int unsigned CntW = $clog2(us_to_cyc(PhaseMaxUs, CLK_HZ));

    localparam int unsigned LeadMin = us_to_cyc(LeadMinUs, CLK_HZ);
    localparam int unsigned LeadMax = us_to_cyc(LeadMaxUs, CLK_HZ);
    localparam int unsigned DataMin = us_to_cyc(DataMinUs, CLK_HZ);
    localparam int unsigned DataMax = us_to_cyc(DataMaxUs, CLK_HZ);
    localparam int unsigned RptMin  = us_to_cyc(RptMinUs, CLK_HZ);
    localparam int unsigned RptMax  = us_to_cyc(RptMaxUs, CLK_HZ);
    localparam int unsigned MarkMin = us_to_cyc(MarkMinUs, CLK_HZ);
    localparam int unsigned MarkMax = us_to_cyc(MarkMaxUs, CLK_HZ);
    localparam int unsigned ZeroMin = us_to_cyc(ZeroMinUs, CLK_HZ);
    localparam int unsigned ZeroMax = us_to_cyc(ZeroMaxUs, CLK_HZ);
    localparam int unsigned OneMin  = us_to_cyc(OneMinUs, CLK_HZ);
    localparam int unsigned OneMax  = us_to_cyc(OneMaxUs, CLK_HZ);
    localparam int unsigned StopMin = us_to_cyc(StopMinUs, CLK_HZ);
    localparam int unsigned StopMax = us_to_cyc(StopMaxUs, CLK_HZ);

    logic            level, rise, fall;
    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic [4:0]      bit_q, bit_d;
    logic [31:0]     sh_q, sh_d;
    logic            rpt_q, rpt_d;
    logic            last_ok_q, last_ok_d;
    logic [7:0]      addr_q, addr_d, data_q, data_d;
    logic            valid_q, valid_d, repeat_q, repeat_d, err_q, err_d;
    logic [31:0]     cnt32;

    ir_input_filter #(
        .FILT_CYC(FILT_CYC)
    ) u_filter (
        .clk  (CLK_50M),
        .rst_n(RST_N),
        .din  (IR_DATA),
        .level(level),
        .rise (rise),
        .fall (fall)
    );

    assign cnt32 = 32'(cnt_q);

    function automatic logic in_win(input logic [31:0] c, input int unsigned lo,
                                    input int unsigned hi);
        return (c >= lo) && (c <= hi);
    endfunction

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        rpt_d     = rpt_q;
        last_ok_d = last_ok_q;
        addr_d    = addr_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        repeat_d  = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (fall) state_d = StLeadL;
            end
            StLeadL: begin
                if (rise) begin
                    if (in_win(cnt32, LeadMin, LeadMax)) state_d = StLeadH;
                    else err_d = 1'b1;
                end else if (cnt32 > LeadMax) begin
                    err_d = 1'b1;
                end
            end
            StLeadH: begin
                if (fall) begin
                    if (in_win(cnt32, DataMin, DataMax)) begin
                        state_d = StBitL;
                        bit_d   = '0;
                        rpt_d   = 1'b0;
                    end else if (in_win(cnt32, RptMin, RptMax)) begin
                        state_d = REPEAT_EN ? StStop : StIdle;
                        rpt_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (cnt32 > DataMax) begin
                    err_d = 1'b1;
                end
            end
            StBitL: begin
                if (rise) begin
                    if (in_win(cnt32, MarkMin, MarkMax)) state_d = StBitH;
                    else err_d = 1'b1;
                end else if (cnt32 > MarkMax) begin
                    err_d = 1'b1;
                end
            end
            StBitH: begin
                if (fall) begin
                    if (in_win(cnt32, ZeroMin, ZeroMax) || in_win(cnt32, OneMin, OneMax)) begin
                        sh_d    = {in_win(cnt32, OneMin, OneMax), sh_q[31:1]};
                        bit_d   = bit_q + 5'd1;
                        state_d = (bit_q == 5'd31) ? StStop : StBitL;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (cnt32 > OneMax) begin
                    err_d = 1'b1;
                end
            end
            StStop: begin
                if (rise) begin
                    state_d = StIdle;
                    if (!in_win(cnt32, StopMin, StopMax)) begin
                        err_d = 1'b1;
                    end else if (rpt_q) begin
                        repeat_d = last_ok_q;
                    end else if ((sh_q[7:0] ^ sh_q[15:8]) != 8'hFF ||
                                 (sh_q[23:16] ^ sh_q[31:24]) != 8'hFF) begin
                        err_d = 1'b1;
                    end else if (ADDR_CHECK && sh_q[7:0] != ADDR) begin
                        last_ok_d = 1'b0;
                    end else begin
                        addr_d    = sh_q[7:0];
                        data_d    = sh_q[23:16];
                        valid_d   = 1'b1;
                        last_ok_d = 1'b1;
                    end
                end else if (cnt32 > StopMax) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (err_d) begin
            state_d   = StIdle;
            last_ok_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            rpt_q     <= 1'b0;
            last_ok_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            repeat_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            // Restart at 1 so the count seen at the next edge equals the phase length.
            if (rise || fall) cnt_q <= CntW'(1);
            else if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            rpt_q     <= rpt_d;
            last_ok_q <= last_ok_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            repeat_q  <= repeat_d;
            err_q     <= err_d;
        end
    end

    assign o_ir_addr = addr_q;
    assign o_ir_data = data_q;
    assign o_valid   = valid_q;
    assign o_repeat  = repeat_q;
    assign o_err     = err_q;
    assign o_busy    = (state_q != StIdle);

endmodule
